button_debounce: RTL

Upstream conditioning stage for the toggle register. It takes a raw, bouncing, asynchronous push-button level and synchronizes it into the `clk` domain. It filters out glitches shorter than a programmable stable window. For each debounced press it emits exactly one single-cycle `toggle` pulse, which drives the `toggle` input of the toggle register directly. It also exposes the debounced level and a busy flag for status and LED use.

---
 rtl/button_debounce_pkg.sv | 17 +
 rtl/sync_chain.sv | 28 ++
 rtl/button_debounce.sv | 111 +++++++++++
 3 files changed

// File: rtl/button_debounce_pkg.sv
// Shared types and sizing helpers for the push-button debouncer.
package button_debounce_pkg;

  // Debouncer FSM states: two stable levels plus a qualifying state for each direction
  typedef enum logic [1:0] {
    IDLE_LOW   = 2'd0,
    CHECK_HIGH = 2'd1,
    HELD_HIGH  = 2'd2,
    CHECK_LOW  = 2'd3
  } db_state_t;

  // Counter width that can hold values 0..stable_cycles
  function automatic int cnt_width(input int stable_cycles);
    return $clog2(stable_cycles + 1);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a single asynchronous input bit; reusable for any async level.
module sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("sync_chain: SYNC_STAGES must be at least 2");
  end

  logic [SYNC_STAGES-1:0] stages;

  // Shift the raw input through the chain; every stage clears on reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stages <= '0;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer: synchronizes the raw button, qualifies level changes over a
// stable window, and emits one registered toggle pulse per accepted press.
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic toggle,
  output logic level,
  output logic busy
);

  localparam int CNT_W = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (STABLE_CYCLES < 2) begin : g_bad_stable
    $error("button_debounce: STABLE_CYCLES must be at least 2");
  end

  logic             btn_s;
  db_state_t        state;
  db_state_t        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             toggle_nxt;
  logic             level_nxt;

  sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_btn_sync (
    .clk(clk),
    .rst(rst),
    .d  (btn),
    .q  (btn_s)
  );

  // State, counter and output registers; reset returns everything to the released-button idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE_LOW;
      cnt    <= '0;
      toggle <= 1'b0;
      level  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      toggle <= toggle_nxt;
      level  <= level_nxt;
    end
  end

  // Next-state logic: a change is accepted only after STABLE_CYCLES identical samples
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    toggle_nxt = 1'b0;
    level_nxt  = level;
    case (state)
      IDLE_LOW: begin
        if (btn_s) begin
          state_nxt = CHECK_HIGH;
          cnt_nxt   = CNT_ONE;
        end
      end
      CHECK_HIGH: begin
        if (!btn_s) begin
          state_nxt = IDLE_LOW;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt  = HELD_HIGH;
          cnt_nxt    = '0;
          level_nxt  = 1'b1;
          toggle_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      HELD_HIGH: begin
        if (!btn_s) begin
          state_nxt = CHECK_LOW;
          cnt_nxt   = CNT_ONE;
        end
      end
      CHECK_LOW: begin
        if (btn_s) begin
          state_nxt = HELD_HIGH;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE_LOW;
          cnt_nxt   = '0;
          level_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE_LOW;
        cnt_nxt   = '0;
        level_nxt = 1'b0;
      end
    endcase
  end

  assign busy = (state == CHECK_HIGH) || (state == CHECK_LOW);

endmodule
